pool2x2_stream_mc: RTL and testbench
====================================

POOL2X2_STREAM_MC -- requirements
Module: pool2x2_stream_mc

Interface
REQ-001 SHALL have parameter P_WIDTH, default 64: input frame width in pixels; even, at least 2.
REQ-002 SHALL have parameter P_HEIGHT, default 64: input frame height in lines; even, at least 2.
REQ-003 SHALL have parameter P_CH, default 4: channels packed per beat; at least 1.
REQ-004 SHALL have parameter DW, default 24: unsigned bits per channel.
REQ-005 SHALL have ports: CLK input 1 clock; RSTn input 1, synchronous, active-low reset.
REQ-006 SHALL have ports: DIN input P_CH*DW, channel c in bits [c*DW +: DW]; DIN_VALID input 1; DIN_READY output 1.
REQ-007 SHALL have ports: MODE input 1, 0 = max, 1 = average; OUT output P_CH*DW; OUT_VALID output 1; OUT_READY input 1.
REQ-008 SHALL have ports: LAST_IN_LINE output 1, with the last output of each output row; LAST_PIX output 1, with the last output of the frame.

Function
REQ-009 SHALL accept a beat only when DIN_VALID and DIN_READY are both high. Pixels arrive in raster order.
REQ-010 SHALL drive DIN_READY = ~OUT_VALID | OUT_READY (combinational). No input is lost under backpressure.
REQ-011 SHALL keep a column counter h (0..P_WIDTH-1) and a row counter v (0..P_HEIGHT-1). Both advance on accepted beats only. h wraps to 0 at P_WIDTH-1 and increments v. v wraps to 0 at P_HEIGHT-1.
REQ-012 SHALL use states S_ROW_EVEN (v even) and S_ROW_ODD (v odd). S_ROW_EVEN goes to S_ROW_ODD on the accepted beat with h=P_WIDTH-1. S_ROW_ODD goes back to S_ROW_EVEN on the same condition.
REQ-013 SHALL, per channel, latch the pixel at even h. At odd h it SHALL form the pair result: max(latched, current) in max mode, or the (DW+1)-bit sum in average mode.
REQ-014 SHALL, in S_ROW_EVEN, write each pair result to line-buffer address h>>1.
REQ-015 SHALL, in S_ROW_ODD, combine each pair result with the line-buffer entry at h>>1 to form the window result: max of the two, or (sum of four, DW+2 bits) >> 2 truncated to DW bits.
REQ-016 SHALL register the window result into OUT and set OUT_VALID on the cycle after the accepted odd-h beat of an odd row. Latency is 1 cycle.
REQ-017 SHALL hold OUT, OUT_VALID, LAST_IN_LINE and LAST_PIX stable while OUT_VALID=1 and OUT_READY=0.
REQ-018 SHALL clear OUT_VALID when OUT_READY=1 and no new result is produced in the same cycle. A simultaneous drain and new result loads the new result.
REQ-019 SHALL set LAST_IN_LINE for the result produced from h=P_WIDTH-1. It SHALL set LAST_PIX when, in addition, v=P_HEIGHT-1.
REQ-020 SHALL sample MODE only on the accepted beat with h=0 and v=0. The sampled mode holds for the whole frame.
REQ-021 SHALL produce exactly (P_WIDTH/2)*(P_HEIGHT/2) outputs per frame. Back-to-back frames need no idle cycle.
REQ-022 SHALL compare all values as unsigned.

Reset
REQ-023 SHALL, when RSTn=0 at a clock edge, clear OUT to 0, clear OUT_VALID, LAST_IN_LINE and LAST_PIX to 0, zero h, v and the sampled mode (max), and enter S_ROW_EVEN.
REQ-024 SHALL, on reset mid-frame, discard the partial frame. The next accepted beat is pixel (0,0). Line-buffer contents are not cleared.

Configuration
REQ-025 SHALL, with macro POOL_AVG_EN defined, implement average mode per REQ-013, REQ-015 and REQ-020.
REQ-026 SHALL, without POOL_AVG_EN, ignore MODE, always use max mode, and contain no adder logic.

Structure
REQ-027 SHALL take the following from shared package pool_pkg: mode encodings POOL_MODE_MAX=0 and POOL_MODE_AVG=1, the state enum, and function pool_clog2 used for counter widths.
REQ-028 SHALL instantiate one sub-module, pool_line_buf: a simple dual-port memory, depth P_WIDTH/2, width P_CH*(DW+1), with synchronous write and combinational read.
REQ-029 SHALL include an elaboration check that fails when P_WIDTH or P_HEIGHT is odd.

Verification
REQ-030 Max, P_WIDTH=4, P_HEIGHT=2, P_CH=1, input 1,5,2,7 then 3,4,8,6 -> OUT 5 (LAST_IN_LINE=0), then OUT 8 (LAST_IN_LINE=1, LAST_PIX=1).
REQ-031 Average, same frame, POOL_AVG_EN defined, MODE=1 -> OUT 3 (13>>2), then OUT 5 (23>>2).
REQ-032 P_CH=2, DW=8, all channel 0 = 255, all channel 1 = 0, average mode -> every output has channel 0 = 255 and channel 1 = 0 (no overflow).
REQ-033 OUT_READY=0 for 10 cycles with DIN_VALID=1 -> OUT stable, DIN_READY=0 after the first result, and no result dropped or duplicated once OUT_READY=1.
REQ-034 MODE toggled mid-frame -> the frame keeps its sampled mode; the next frame uses the new MODE.
REQ-035 RSTn pulsed after 37 accepted beats of a 64x64 frame, then a full frame sent -> exactly 1024 outputs, LAST_PIX only on the 1024th.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling stream: mode encodings, row-phase states
// and the width helper used to size counters.
package pool_pkg;

    localparam logic POOL_MODE_MAX = 1'b0;
    localparam logic POOL_MODE_AVG = 1'b1;

    typedef enum logic {
        S_ROW_EVEN = 1'b0,
        S_ROW_ODD  = 1'b1
    } pool_state_e;

    // Minimum of one bit so that a depth of 1 still yields a usable address.
    function automatic int unsigned pool_clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer: synchronous write, combinational read, no reset
// (contents are always rewritten by an even row before an odd row reads them).
module pool_line_buf #(
    parameter int unsigned P_DEPTH  = 32,
    parameter int unsigned P_DATA_W = 100,
    parameter int unsigned P_ADDR_W = 5
) (
    input  logic                CLK,
    input  logic                i_we,
    input  logic [P_ADDR_W-1:0] i_waddr,
    input  logic [P_DATA_W-1:0] i_wdata,
    input  logic [P_ADDR_W-1:0] i_raddr,
    output logic [P_DATA_W-1:0] o_rdata
);

    logic [P_DATA_W-1:0] r_mem [P_DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool2x2_stream_mc.sv
// Streaming 2x2 max/average pooling over raster-order multi-channel pixels.
// Average mode is compiled in only when POOL_AVG_EN is defined; otherwise max only.
module pool2x2_stream_mc
    import pool_pkg::*;
#(
    parameter int unsigned P_WIDTH  = 64,
    parameter int unsigned P_HEIGHT = 64,
    parameter int unsigned P_CH     = 4,
    parameter int unsigned DW       = 24
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [P_CH*DW-1:0] DIN,
    input  logic               DIN_VALID,
    output logic               DIN_READY,
    input  logic               MODE,
    output logic [P_CH*DW-1:0] OUT,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               LAST_IN_LINE,
    output logic               LAST_PIX
);

    localparam int unsigned HW  = pool_clog2(P_WIDTH);
    localparam int unsigned VW  = pool_clog2(P_HEIGHT);
    localparam int unsigned AW  = pool_clog2(P_WIDTH / 2);
    localparam int unsigned LBW = P_CH * (DW + 1);

    if ((P_WIDTH % 2) != 0 || (P_HEIGHT % 2) != 0 || P_WIDTH < 2 || P_HEIGHT < 2)
    begin : g_bad_geometry
        $error("pool2x2_stream_mc: P_WIDTH and P_HEIGHT must be even and at least 2");
    end

    logic [HW-1:0]      r_h;
    logic [VW-1:0]      r_v;
    pool_state_e        r_state;
    logic [P_CH*DW-1:0] r_latch;
    logic [P_CH*DW-1:0] r_out;
    logic               r_out_valid;
    logic               r_last_line;
    logic               r_last_pix;

    logic               w_accept;
    logic               w_h_odd;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_produce;
    logic               w_lb_we;
    logic [AW-1:0]      w_lb_addr;
    logic [LBW-1:0]     w_pair;
    logic [LBW-1:0]     w_lb_rdata;
    logic [P_CH*DW-1:0] w_win;

`ifdef POOL_AVG_EN
    logic r_mode;
`else
    logic w_unused_mode;
    assign w_unused_mode = MODE;
`endif

    assign DIN_READY = ~r_out_valid | OUT_READY;
    assign w_accept  = DIN_VALID & DIN_READY;
    assign w_h_odd   = r_h[0];
    assign w_h_last  = (r_h == HW'(P_WIDTH - 1));
    assign w_v_last  = (r_v == VW'(P_HEIGHT - 1));
    assign w_produce = w_accept & (r_state == S_ROW_ODD) & w_h_odd;
    assign w_lb_we   = w_accept & (r_state == S_ROW_EVEN) & w_h_odd;
    assign w_lb_addr = AW'(r_h >> 1);

    for (genvar c = 0; c < P_CH; c++) begin : g_ch
        logic [DW-1:0] w_cur;
        logic [DW-1:0] w_lat;
        logic [DW:0]   w_lb;
        logic [DW-1:0] w_pmax;
        logic [DW-1:0] w_wmax;

        assign w_cur  = DIN[c*DW +: DW];
        assign w_lat  = r_latch[c*DW +: DW];
        assign w_lb   = w_lb_rdata[c*(DW+1) +: DW+1];
        assign w_pmax = (w_cur > w_lat) ? w_cur : w_lat;
        // Max-mode entries are zero-extended, so the low DW bits are the whole value.
        assign w_wmax = (w_pmax > w_lb[DW-1:0]) ? w_pmax : w_lb[DW-1:0];
`ifdef POOL_AVG_EN
        logic [DW:0]   w_psum;
        logic [DW+1:0] w_wsum;
        logic [1:0]    w_unused_frac;

        assign w_psum        = {1'b0, w_lat} + {1'b0, w_cur};
        assign w_wsum        = {1'b0, w_psum} + {1'b0, w_lb};
        assign w_unused_frac = w_wsum[1:0];
        assign w_pair[c*(DW+1) +: DW+1] = (r_mode == POOL_MODE_AVG) ? w_psum : {1'b0, w_pmax};
        assign w_win[c*DW +: DW]        = (r_mode == POOL_MODE_AVG) ? w_wsum[DW+1:2] : w_wmax;
`else
        logic w_unused_msb;

        assign w_unused_msb             = w_lb[DW];
        assign w_pair[c*(DW+1) +: DW+1] = {1'b0, w_pmax};
        assign w_win[c*DW +: DW]        = w_wmax;
`endif
    end

    pool_line_buf #(
        .P_DEPTH  (P_WIDTH / 2),
        .P_DATA_W (LBW),
        .P_ADDR_W (AW)
    ) u_line_buf (
        .CLK     (CLK),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_pair),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_h         <= '0;
            r_v         <= '0;
            r_state     <= S_ROW_EVEN;
            r_latch     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_last_line <= 1'b0;
            r_last_pix  <= 1'b0;
`ifdef POOL_AVG_EN
            r_mode      <= POOL_MODE_MAX;
`endif
        end else begin
            if (w_accept) begin
`ifdef POOL_AVG_EN
                if (r_h == '0 && r_v == '0) r_mode <= MODE;
`endif
                if (!w_h_odd) r_latch <= DIN;
                if (w_h_last) begin
                    r_h     <= '0;
                    r_v     <= w_v_last ? '0 : r_v + 1'b1;
                    r_state <= (r_state == S_ROW_EVEN) ? S_ROW_ODD : S_ROW_EVEN;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
            // A new result wins over a drain in the same cycle.
            if (w_produce) begin
                r_out       <= w_win;
                r_out_valid <= 1'b1;
                r_last_line <= w_h_last;
                r_last_pix  <= w_h_last & w_v_last;
            end else if (OUT_READY) begin
                r_out_valid <= 1'b0;
                r_last_line <= 1'b0;
                r_last_pix  <= 1'b0;
            end
        end
    end

    assign OUT          = r_out;
    assign OUT_VALID    = r_out_valid;
    assign LAST_IN_LINE = r_last_line;
    assign LAST_PIX     = r_last_pix;

endmodule

// File: tb/tb_pool2x2_stream_mc.sv
// Directed bench for pool2x2_stream_mc on a 4x2 frame, two 8-bit channels.
// Expectations follow POOL_AVG_EN: average results only when the macro is defined.
module tb_pool2x2_stream_mc;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned CH = 2;
    localparam int unsigned D  = 8;
`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] ch0;
        logic [63:0] ch1;
        logic        mode;
        logic [31:0] exp_max;
        logic [31:0] exp_avg;
    } vec_t;

    logic          clk;
    logic          rstn;
    logic [15:0]   din;
    logic          din_valid;
    logic          din_ready;
    logic          mode;
    logic [15:0]   dout;
    logic          out_valid;
    logic          out_ready;
    logic          last_in_line;
    logic          last_pix;

    int            n_checks;
    int            n_fail;
    logic [17:0]   q_out [$];
    vec_t          vecs [5];

    pool2x2_stream_mc #(
        .P_WIDTH  (W),
        .P_HEIGHT (H),
        .P_CH     (CH),
        .DW       (D)
    ) dut (
        .CLK          (clk),
        .RSTn         (rstn),
        .DIN          (din),
        .DIN_VALID    (din_valid),
        .DIN_READY    (din_ready),
        .MODE         (mode),
        .OUT          (dout),
        .OUT_VALID    (out_valid),
        .OUT_READY    (out_ready),
        .LAST_IN_LINE (last_in_line),
        .LAST_PIX     (last_pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed output handshake; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) q_out.push_back({dout, last_in_line, last_pix});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pk8(input int unsigned a0, a1, a2, a3, a4, a5, a6, a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [31:0] eff(input logic m, input logic [31:0] mx, input logic [31:0] av);
        return (AVG_EN && m) ? av : mx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic m);
        logic acc;
        din       = d;
        mode      = m;
        din_valid = 1'b1;
        acc       = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = din_ready;
            step();
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input logic [63:0] c0, input logic [63:0] c1, input logic m_first,
                              input logic m_rest, input int nbeats);
        for (int i = 0; i < nbeats; i++)
            send_beat({c1[i*8 +: 8], c0[i*8 +: 8]}, (i == 0) ? m_first : m_rest);
        din_valid = 1'b0;
    endtask

    task automatic check_frame(input logic [31:0] exp, input string tag);
        logic [17:0] e;
        repeat (4) step();
        chk({tag, "_count"}, 32'(q_out.size()), 32'd2);
        if (q_out.size() == 2) begin
            for (int k = 0; k < 2; k++) begin
                e = q_out.pop_front();
                chk($sformatf("%s_out%0d", tag, k), 32'(e[17:2]), 32'(exp[k*16 +: 16]));
                chk($sformatf("%s_lil%0d", tag, k), 32'(e[1]), 32'(k == 1));
                chk($sformatf("%s_lp%0d", tag, k), 32'(e[0]), 32'(k == 1));
            end
        end
        q_out.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;

        // ch0/ch1 pixels in raster order; results packed as {out1, out0}, each {ch1, ch0}.
        vecs[0] = '{pk8(1, 5, 2, 7, 3, 4, 8, 6), pk8(0, 0, 0, 0, 0, 0, 0, 0), 1'b1,
                    32'h0008_0005, 32'h0005_0003};
        vecs[1] = '{pk8(255, 255, 255, 255, 255, 255, 255, 255), pk8(0, 0, 0, 0, 0, 0, 0, 0),
                    1'b1, 32'h00FF_00FF, 32'h00FF_00FF};
        vecs[2] = '{pk8(10, 20, 30, 40, 50, 60, 70, 80), pk8(200, 100, 0, 255, 1, 2, 3, 4),
                    1'b1, 32'hFF50_C83C, 32'h4137_4B23};
        vecs[3] = '{pk8(10, 20, 30, 40, 50, 60, 70, 80), pk8(200, 100, 0, 255, 1, 2, 3, 4),
                    1'b0, 32'hFF50_C83C, 32'h4137_4B23};
        vecs[4] = '{pk8(128, 127, 0, 0, 0, 0, 0, 1), pk8(3, 3, 3, 3, 2, 2, 2, 2),
                    1'b1, 32'h0301_0380, 32'h0200_023F};

        repeat (3) step();
        chk("rst_out", 32'(dout), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_lil", 32'(last_in_line), 32'd0);
        chk("rst_lp", 32'(last_pix), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].ch0, vecs[i].ch1, vecs[i].mode, vecs[i].mode, 8);
            check_frame(eff(vecs[i].mode, vecs[i].exp_max, vecs[i].exp_avg),
                        $sformatf("vec%0d", i));
        end

        // Backpressure: stall the first result for 10 cycles with input pending.
        out_ready = 1'b0;
        send_frame(vecs[3].ch0, vecs[3].ch1, 1'b0, 1'b0, 6);
        chk("bp_latency_valid", 32'(out_valid), 32'd1);
        chk("bp_first_out", 32'(dout), 32'h0000_C83C);
        din       = {vecs[3].ch1[55:48], vecs[3].ch0[55:48]};
        din_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_din_ready", 32'(din_ready), 32'd0);
            chk("bp_hold_out", 32'(dout), 32'h0000_C83C);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_lil", 32'(last_in_line), 32'd0);
        end
        step();
        out_ready = 1'b1;
        send_beat({vecs[3].ch1[55:48], vecs[3].ch0[55:48]}, 1'b0);
        send_beat({vecs[3].ch1[63:56], vecs[3].ch0[63:56]}, 1'b0);
        din_valid = 1'b0;
        check_frame(32'hFF50_C83C, "bp");

        // MODE changes after pixel (0,0) must not affect the running frame.
        send_frame(vecs[2].ch0, vecs[2].ch1, 1'b0, 1'b1, 8);
        check_frame(32'hFF50_C83C, "mode_keep");
        send_frame(vecs[2].ch0, vecs[2].ch1, 1'b1, 1'b0, 8);
        check_frame(eff(1'b1, 32'hFF50_C83C, 32'h4137_4B23), "mode_next");

        // Reset mid-frame: partial frame discarded, next beat is pixel (0,0).
        send_frame(vecs[2].ch0, vecs[2].ch1, 1'b0, 1'b0, 7);
        repeat (2) step();
        q_out.delete();
        rstn = 1'b0;
        step();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(dout), 32'd0);
        rstn = 1'b1;
        step();
        send_frame(vecs[0].ch0, vecs[0].ch1, 1'b0, 1'b0, 8);
        check_frame(32'h0008_0005, "midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
